// File: rtl/shift_unit_pkg.sv
// Shared mode/direction constants and controller state type for the shift unit.
package shift_unit_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFin
  } state_e;

endpackage

// File: rtl/shift_step_p.sv
// One-bit shift step: the vacated end is filled according to mode, the exiting bit is reported.
module shift_step_p
  import shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             s_in,
  output logic [WIDTH-1:0] nxt,
  output logic             out_bit
);

  logic fill;

  always_comb begin
    fill    = 1'b0;
    nxt     = cur;
    out_bit = 1'b0;
    if (dir == DIR_R) begin
      unique case (mode)
        MODE_LOG: fill = 1'b0;
        MODE_ARI: fill = cur[WIDTH-1];
        MODE_ROT: fill = cur[0];
        MODE_SER: fill = s_in;
      endcase
      nxt     = {fill, cur[WIDTH-1:1]};
      out_bit = cur[0];
    end else begin
      // Arithmetic left behaves like logical left.
      unique case (mode)
        MODE_LOG: fill = 1'b0;
        MODE_ARI: fill = 1'b0;
        MODE_ROT: fill = cur[WIDTH-1];
        MODE_SER: fill = s_in;
      endcase
      nxt     = {cur[WIDTH-2:0], fill};
      out_bit = cur[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_unit_p.sv
// Datapath shift register: parallel load, legacy single right step and a counted
// multi-cycle shift engine with busy/done handshake.
module shift_unit_p
  import shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             sft,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             s_in,
  output logic [WIDTH-1:0] dout,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sout_q, sout_d;

  logic [CNT_W-1:0] eff_amt;
  logic             step_dir;
  logic [1:0]       step_mode;
  logic [WIDTH-1:0] step_nxt;
  logic             step_out;

  // Rotation wraps; every other mode saturates at a full-width shift.
  always_comb begin
    eff_amt = amt;
    if (mode == MODE_ROT) begin
      eff_amt = amt % WidthCnt;
    end else if (amt > WidthCnt) begin
      eff_amt = WidthCnt;
    end
  end

  // Outside SHIFT the stepper serves the legacy path as a serial-in right shift.
  assign step_dir  = (state_q == StShift) ? dir_q  : DIR_R;
  assign step_mode = (state_q == StShift) ? mode_q : MODE_SER;

  shift_step_p #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur     (dout_q),
    .dir     (step_dir),
    .mode    (step_mode),
    .s_in    (s_in),
    .nxt     (step_nxt),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    sout_d  = sout_q;

    if (clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      dout_d  = '0;
      sout_d  = 1'b0;
    end else begin
      case (state_q)
        StShift: begin
          dout_d = step_nxt;
          sout_d = step_out;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = StFin;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          if (ld) begin
            dout_d = din;
          end else if (start) begin
            dir_d   = dir;
            mode_d  = mode;
            cnt_d   = eff_amt;
            state_d = (eff_amt == '0) ? StFin : StShift;
          end else if (sft) begin
            dout_d = step_nxt;
            sout_d = step_out;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      mode_q  <= MODE_LOG;
      dout_q  <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
    end
  end

  assign dout  = dout_q;
  assign s_out = sout_q;
  assign busy  = (state_q == StShift);
  assign done  = (state_q == StFin);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_shift_cnt_live: assert property (@(posedge clk) disable iff (rst)
                                     (state_q == StShift) |-> (cnt_q != '0));

endmodule
